udp_txbuf_builder: RTL and testbench
====================================

# udp_txbuf_builder

- Packs an application byte stream plus destination/port metadata into the word-addressed UDP TX buffer layout consumed by `ros2_ether`.
- Serves that buffer to the engine's `udp_txbuf_*` read port.
- Sits directly upstream of `ros2_ether` and replaces hand-built TX ROMs/RAMs in user designs.
- Owns the grant/release handshake: it writes only while granted and releases one complete frame per grant.

## Interface
- `AWIDTH`, default `` `UDP_TXBUF_AWIDTH `` (6): buffer word-address width; depth 2^AWIDTH words.
- `MAX_PAYLOAD`, default (2^AWIDTH−3)*4 (244): maximum payload bytes.

- `clk`  in  1  sole clock.
- `rst`  in  1  reset; synchronous, active-high.
- `app_start`  in  1  begin a frame; sampled only when `app_start_ready`=1.
- `app_start_ready`  out  1  high in IDLE while `udp_txbuf_grant`=1.
- `app_dst_ip`  in  32  destination IP, byte 0 (first octet) in [7:0]; latched on start.
- `app_src_port`  in  16  source port; latched on start.
- `app_dst_port`  in  16  destination port; latched on start.
- `app_tdata`  in  8  payload byte.
- `app_tvalid`  in  1  byte valid.
- `app_tlast`  in  1  final byte of frame.
- `app_tready`  out  1  byte accepted when `tvalid`&`tready`.
- `busy`  out  1  high whenever state ≠ IDLE.
- `frame_sent`  out  1  one-cycle pulse, coincident with `udp_txbuf_rel`.
- `frame_dropped`  out  1  one-cycle pulse on abort or discard.
- `udp_txbuf_grant`  in  1  from engine; 1 = builder owns buffer.
- `udp_txbuf_rel`  out  1  one-cycle pulse handing a finished frame to the engine.
- `udp_txbuf_addr`  in  AWIDTH  engine read address.
- `udp_txbuf_ce`  in  1  engine read enable.
- `udp_txbuf_rdata`  out  32  read data.

## Operation
Buffer layout:
- Word 0: `dst_ip`.
- Word 1: {`src_port`, `dst_port`}.
- Word 2: payload length in bytes, zero-extended.
- Words 3 onward: payload, packed LSB-first (byte k goes in word 3+k/4, bits [8*(k%4)+7 : 8*(k%4)]).
- Unused upper bytes of the final word are written as 0.

State machine IDLE → PAYLOAD → HDR0 → HDR1 → HDR2 → REL → IDLE:
- **IDLE**: on `app_start`&`app_start_ready`, latch the metadata, clear the byte counter and pack register, go to PAYLOAD.
- **PAYLOAD**: `app_tready`=1. Each accepted byte goes into the pack register.
  - A word is written at the 4th byte, or on the `tlast` byte if it completes a partial word.
  - Write happens in the same cycle the byte is accepted.
  - After `tlast` is accepted, go to HDR0.
- **HDR0/1/2**: write words 0/1/2, one per cycle.
- **REL**: `udp_txbuf_rel`=1 and `frame_sent`=1 for one cycle, then IDLE.
- After REL, a new start is possible only once the engine re-asserts grant.

Length rules:
- Payload is ≥1 byte; the frame ends only with a `tlast` byte.
- Byte counter is 16 bits. Bytes beyond `MAX_PAYLOAD` are never written to memory.
- Oversize handling is set by the Configuration macro.

Grant loss:
- If `udp_txbuf_grant` falls in PAYLOAD or HDRx: abort, pulse `frame_dropped`, return to IDLE. Memory writes stop that cycle.
- Bytes arriving after the abort are not accepted (`app_tready`=0).

Read port:
- `udp_txbuf_rdata` <= mem[`udp_txbuf_addr`] on `udp_txbuf_ce`; otherwise it holds.
- Reads are legal in any state.
- A same-cycle write to the read address returns the old data.

## Timing
- Reset values:
  - State IDLE.
  - `app_tready`=0, `busy`=0, `frame_sent`=0, `frame_dropped`=0, `udp_txbuf_rel`=0, `udp_txbuf_rdata`=0.
  - `app_start_ready` follows grant combinationally.
  - Memory contents undefined.
- `rst` mid-frame: return to IDLE next cycle with no `rel` and no `frame_dropped`.
- Throughput: 1 byte/cycle in PAYLOAD.
- Latency: `tlast` accepted at cycle N → header words written N+1..N+3 → `udp_txbuf_rel` high at N+4.
- Read latency: 1 cycle from `udp_txbuf_ce`.
- `app_start` asserted outside IDLE is ignored.

## Configuration
- `UDP_TXBUF_OVERSIZE_DROP_EN` defined:
  - A frame exceeding `MAX_PAYLOAD` is consumed through `tlast`.
  - It is then discarded with a `frame_dropped` pulse and no header write or `rel`.
- `UDP_TXBUF_OVERSIZE_DROP_EN` undefined:
  - The frame is truncated; excess bytes are accepted and discarded.
  - Word 2 = `MAX_PAYLOAD`; `rel` is issued normally.

## Test plan
- **Basic frame**: grant=1; start with ip 192.168.1.10, src 1111, dst 1234; 13 bytes "UDP Send Test".
  - Words 0..6 read back as 0a01a8c0, 045704d2, 0000000d, 20504455, 646e6553, 73655420, 00000074.
  - `rel` is asserted 4 cycles after `tlast`.
- **Single-byte payload** 0xAB: word 2 = 1, word 3 = 000000ab, one `frame_sent` pulse.
- **Back-pressure-free stream with gaps**: `tvalid` toggles every other cycle for 8 bytes. Packing is identical to the gap-free case; `rel` comes 4 cycles after `tlast`.
- **Grant drop** after 5 bytes: `frame_dropped` pulses, no `rel`, state returns to IDLE, and the next frame after grant returns is correct.
- **Oversize**: 250 bytes with `AWIDTH`=6.
  - Macro defined: `frame_dropped`, no `rel`.
  - Macro undefined: word 2 = 244, `rel` asserted, word 63 holds bytes 240..243.
- **Reset mid-PAYLOAD**: `rst` for 1 cycle. All outputs return to their reset values, and a subsequent frame completes correctly.

Source files
------------

// File: rtl/udp_txbuf_builder.sv
// udp_txbuf_builder: packs an app byte stream plus UDP metadata into the ros2_ether TX buffer.
// Define UDP_TXBUF_OVERSIZE_DROP_EN to discard oversize frames instead of truncating them.
`ifndef UDP_TXBUF_AWIDTH
`define UDP_TXBUF_AWIDTH 6
`endif

module udp_txbuf_builder #(
    parameter int AWIDTH      = `UDP_TXBUF_AWIDTH,
    parameter int MAX_PAYLOAD = ((1 << AWIDTH) - 3) * 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              app_start,
    output logic              app_start_ready,
    input  logic [31:0]       app_dst_ip,
    input  logic [15:0]       app_src_port,
    input  logic [15:0]       app_dst_port,
    input  logic [7:0]        app_tdata,
    input  logic              app_tvalid,
    input  logic              app_tlast,
    output logic              app_tready,
    output logic              busy,
    output logic              frame_sent,
    output logic              frame_dropped,
    input  logic              udp_txbuf_grant,
    output logic              udp_txbuf_rel,
    input  logic [AWIDTH-1:0] udp_txbuf_addr,
    input  logic              udp_txbuf_ce,
    output logic [31:0]       udp_txbuf_rdata
);

    localparam int          DEPTH   = 1 << AWIDTH;
    localparam logic [15:0] MAX_LEN = 16'(MAX_PAYLOAD);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PAYLOAD,
        S_HDR0,
        S_HDR1,
        S_HDR2,
        S_REL
    } state_t;

    state_t state, state_nxt;

    logic [31:0] mem [DEPTH];

    logic [31:0] dst_ip_q;
    logic [15:0] src_port_q;
    logic [15:0] dst_port_q;
    logic [15:0] cnt_q;
    logic [31:0] pack_q;
    logic        over_q;
    logic        regrant_q;
    logic        dropped_q;

    logic              start;
    logic              accept;
    logic              in_range;
    logic              lane_last;
    logic              overflow;
    logic              drop_now;
    logic [31:0]       pack_word;
    logic [AWIDTH-1:0] pay_addr;
    logic              we;
    logic [AWIDTH-1:0] waddr;
    logic [31:0]       wdata;

    // A released buffer may only be refilled after the engine cycles grant.
    assign app_start_ready = (state == S_IDLE) & udp_txbuf_grant & ~regrant_q;
    assign start           = app_start & app_start_ready;
    assign app_tready      = (state == S_PAYLOAD) & udp_txbuf_grant;
    assign accept          = app_tvalid & app_tready;
    assign busy            = (state != S_IDLE);
    assign udp_txbuf_rel   = (state == S_REL);
    assign frame_sent      = (state == S_REL);
    assign frame_dropped   = dropped_q;

    assign in_range  = (cnt_q < MAX_LEN);
    assign lane_last = (cnt_q[1:0] == 2'd3);
    assign overflow  = over_q | ~in_range;
    assign pack_word = pack_q | ({24'd0, app_tdata} << {cnt_q[1:0], 3'b000});
    assign pay_addr  = AWIDTH'(cnt_q[15:2] + 14'd3);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        drop_now  = 1'b0;
        we        = 1'b0;
        waddr     = '0;
        wdata     = '0;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_PAYLOAD;
                end
            end
            S_PAYLOAD: begin
                if (!udp_txbuf_grant) begin
                    state_nxt = S_IDLE;
                    drop_now  = 1'b1;
                end else if (accept) begin
                    waddr = pay_addr;
                    if (in_range) begin
                        we    = lane_last | app_tlast;
                        wdata = pack_word;
                    end else begin
                        // Flush a partial word left behind by truncation.
                        we    = app_tlast & (cnt_q[1:0] != 2'd0);
                        wdata = pack_q;
                    end
                    if (app_tlast) begin
`ifdef UDP_TXBUF_OVERSIZE_DROP_EN
                        if (overflow) begin
                            state_nxt = S_IDLE;
                            drop_now  = 1'b1;
                        end else begin
                            state_nxt = S_HDR0;
                        end
`else
                        state_nxt = S_HDR0;
`endif
                    end
                end
            end
            S_HDR0: begin
                if (!udp_txbuf_grant) begin
                    state_nxt = S_IDLE;
                    drop_now  = 1'b1;
                end else begin
                    state_nxt = S_HDR1;
                    we        = 1'b1;
                    waddr     = AWIDTH'(0);
                    wdata     = dst_ip_q;
                end
            end
            S_HDR1: begin
                if (!udp_txbuf_grant) begin
                    state_nxt = S_IDLE;
                    drop_now  = 1'b1;
                end else begin
                    state_nxt = S_HDR2;
                    we        = 1'b1;
                    waddr     = AWIDTH'(1);
                    wdata     = {src_port_q, dst_port_q};
                end
            end
            S_HDR2: begin
                if (!udp_txbuf_grant) begin
                    state_nxt = S_IDLE;
                    drop_now  = 1'b1;
                end else begin
                    state_nxt = S_REL;
                    we        = 1'b1;
                    waddr     = AWIDTH'(2);
                    wdata     = {16'd0, cnt_q};
                end
            end
            S_REL: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Counter saturates at MAX_LEN so word 2 carries the truncated length.
    always_ff @(posedge clk) begin
        if (rst) begin
            dst_ip_q   <= '0;
            src_port_q <= '0;
            dst_port_q <= '0;
            cnt_q      <= '0;
            pack_q     <= '0;
            over_q     <= 1'b0;
            regrant_q  <= 1'b0;
            dropped_q  <= 1'b0;
        end else begin
            dropped_q <= drop_now;
            if (state == S_REL) begin
                regrant_q <= 1'b1;
            end else if (!udp_txbuf_grant) begin
                regrant_q <= 1'b0;
            end
            if (start) begin
                dst_ip_q   <= app_dst_ip;
                src_port_q <= app_src_port;
                dst_port_q <= app_dst_port;
                cnt_q      <= '0;
                pack_q     <= '0;
                over_q     <= 1'b0;
            end else if (accept) begin
                if (in_range) begin
                    cnt_q  <= cnt_q + 16'd1;
                    pack_q <= lane_last ? 32'd0 : pack_word;
                end else begin
                    over_q <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            udp_txbuf_rdata <= '0;
        end else if (udp_txbuf_ce) begin
            udp_txbuf_rdata <= mem[udp_txbuf_addr];
        end
    end

endmodule

// File: tb/tb_udp_txbuf_builder.sv
// tb_udp_txbuf_builder: self-checking bench for udp_txbuf_builder.
// Reference buffer image is rebuilt from the byte queue and layout rules.
module tb_udp_txbuf_builder;

    localparam int AW   = 6;
    localparam int MAXP = ((1 << AW) - 3) * 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          app_start;
    logic          app_start_ready;
    logic [31:0]   app_dst_ip;
    logic [15:0]   app_src_port;
    logic [15:0]   app_dst_port;
    logic [7:0]    app_tdata;
    logic          app_tvalid;
    logic          app_tlast;
    logic          app_tready;
    logic          busy;
    logic          frame_sent;
    logic          frame_dropped;
    logic          udp_txbuf_grant;
    logic          udp_txbuf_rel;
    logic [AW-1:0] udp_txbuf_addr;
    logic          udp_txbuf_ce;
    logic [31:0]   udp_txbuf_rdata;

    always #5 clk = ~clk;

    udp_txbuf_builder #(.AWIDTH(AW)) dut (
        .clk             (clk),
        .rst             (rst),
        .app_start       (app_start),
        .app_start_ready (app_start_ready),
        .app_dst_ip      (app_dst_ip),
        .app_src_port    (app_src_port),
        .app_dst_port    (app_dst_port),
        .app_tdata       (app_tdata),
        .app_tvalid      (app_tvalid),
        .app_tlast       (app_tlast),
        .app_tready      (app_tready),
        .busy            (busy),
        .frame_sent      (frame_sent),
        .frame_dropped   (frame_dropped),
        .udp_txbuf_grant (udp_txbuf_grant),
        .udp_txbuf_rel   (udp_txbuf_rel),
        .udp_txbuf_addr  (udp_txbuf_addr),
        .udp_txbuf_ce    (udp_txbuf_ce),
        .udp_txbuf_rdata (udp_txbuf_rdata)
    );

    typedef struct {
        int          addr;
        logic [31:0] exp;
    } vec_t;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rel_cnt = 0;
    int sent_cnt = 0;
    int drop_cnt = 0;

    logic [7:0] pay[$];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (udp_txbuf_rel) rel_cnt <= rel_cnt + 1;
        if (frame_sent) sent_cnt <= sent_cnt + 1;
        if (frame_dropped) drop_cnt <= drop_cnt + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not end, got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic read_word(input int a, output logic [31:0] d);
        @(negedge clk);
        udp_txbuf_addr = AW'(a);
        udp_txbuf_ce   = 1'b1;
        @(negedge clk);
        udp_txbuf_ce = 1'b0;
        d = udp_txbuf_rdata;
    endtask

    task automatic wait_start_ready(output bit ok);
        int t;
        t = 0;
        while (!app_start_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        ok = app_start_ready;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL start_ready_timeout: got 0 required 1");
        end
    endtask

    task automatic do_start(input logic [31:0] ip, input logic [15:0] sp, input logic [15:0] dp);
        app_start    = 1'b1;
        app_dst_ip   = ip;
        app_src_port = sp;
        app_dst_port = dp;
        @(negedge clk);
        app_start    = 1'b0;
        app_dst_ip   = $urandom;
        app_src_port = 16'($urandom);
        app_dst_port = 16'($urandom);
    endtask

    // gap: 0 none, 1 tvalid every other cycle, 2 random idles
    task automatic send_frame(input logic [31:0] ip, input logic [15:0] sp,
                              input logic [15:0] dp, input int gap,
                              output int lat, output bit rel_seen, output bit drop_seen);
        int t;
        int tlast_edge;
        bit ok;
        lat        = -1;
        rel_seen   = 1'b0;
        drop_seen  = 1'b0;
        tlast_edge = 0;
        @(negedge clk);
        wait_start_ready(ok);
        if (!ok) return;
        do_start(ip, sp, dp);
        for (int k = 0; k < pay.size(); k++) begin
            if ((gap == 1 && k > 0) || (gap == 2 && $urandom_range(1, 0) == 1)) begin
                app_tvalid = 1'b0;
                @(negedge clk);
            end
            app_tvalid = 1'b1;
            app_tdata  = pay[k];
            app_tlast  = (k == pay.size() - 1);
            t = 0;
            while (!app_tready && t < 50) begin
                @(negedge clk);
                t++;
            end
            if (!app_tready) begin
                checks++;
                errors++;
                $display("FAIL tready_timeout: got 0 required 1 at byte %0d", k);
                app_tvalid = 1'b0;
                app_tlast  = 1'b0;
                return;
            end
            tlast_edge = cyc + 1;
            @(negedge clk);
        end
        app_tvalid = 1'b0;
        app_tlast  = 1'b0;
        app_tdata  = 8'($urandom);
        t = 0;
        while (!udp_txbuf_rel && !frame_dropped && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (udp_txbuf_rel) begin
            rel_seen = 1'b1;
            lat      = cyc + 1 - tlast_edge;
        end
        if (frame_dropped) drop_seen = 1'b1;
        // engine takes the buffer, then grants it back
        udp_txbuf_grant = 1'b0;
        @(negedge clk);
        @(negedge clk);
        udp_txbuf_grant = 1'b1;
    endtask

    task automatic verify_frame(input string tag, input logic [31:0] ip,
                                input logic [15:0] sp, input logic [15:0] dp);
        int len;
        logic [31:0] d;
        logic [31:0] e;
        len = (pay.size() > MAXP) ? MAXP : pay.size();
        read_word(0, d);
        check($sformatf("%s w0", tag), d, ip);
        read_word(1, d);
        check($sformatf("%s w1", tag), d, {sp, dp});
        read_word(2, d);
        check($sformatf("%s w2", tag), d, 32'(len));
        for (int w = 0; w < (len + 3) / 4; w++) begin
            e = '0;
            for (int b = 0; b < 4; b++)
                if (4 * w + b < len) e[8*b +: 8] = pay[4*w+b];
            read_word(3 + w, d);
            check($sformatf("%s w%0d", tag, 3 + w), d, e);
        end
    endtask

    task automatic set_pay_string(input string s);
        pay.delete();
        for (int i = 0; i < s.len(); i++) pay.push_back(s[i]);
    endtask

    task automatic frame_case(input string tag, input logic [31:0] ip,
                              input logic [15:0] sp, input logic [15:0] dp, input int gap);
        int lat;
        bit rs;
        bit ds;
        int s0;
        s0 = sent_cnt;
        send_frame(ip, sp, dp, gap, lat, rs, ds);
        check($sformatf("%s rel", tag), 32'(rs), 32'd1);
        check($sformatf("%s latency", tag), 32'(lat), 32'd4);
        check($sformatf("%s sent_pulses", tag), 32'(sent_cnt - s0), 32'd1);
        verify_frame(tag, ip, sp, dp);
    endtask

    vec_t basic_tbl[7];
    vec_t single_tbl[2];

    initial begin
        logic [31:0] d;
        int          lat;
        bit          rs;
        bit          ds;
        bit          ok;
        int          r0;
        int          dr0;

        basic_tbl[0] = '{0, 32'h0a01a8c0};
        basic_tbl[1] = '{1, 32'h045704d2};
        basic_tbl[2] = '{2, 32'h0000000d};
        basic_tbl[3] = '{3, 32'h20504455};
        basic_tbl[4] = '{4, 32'h646e6553};
        basic_tbl[5] = '{5, 32'h73655420};
        basic_tbl[6] = '{6, 32'h00000074};
        single_tbl[0] = '{2, 32'h00000001};
        single_tbl[1] = '{3, 32'h000000ab};

        rst             = 1'b1;
        app_start       = 1'b0;
        app_dst_ip      = '0;
        app_src_port    = '0;
        app_dst_port    = '0;
        app_tdata       = '0;
        app_tvalid      = 1'b0;
        app_tlast       = 1'b0;
        udp_txbuf_grant = 1'b0;
        udp_txbuf_addr  = '0;
        udp_txbuf_ce    = 1'b0;

        repeat (3) @(negedge clk);
        check("rst busy", 32'(busy), 32'd0);
        check("rst tready", 32'(app_tready), 32'd0);
        check("rst rel", 32'(udp_txbuf_rel), 32'd0);
        check("rst sent", 32'(frame_sent), 32'd0);
        check("rst dropped", 32'(frame_dropped), 32'd0);
        check("rst rdata", udp_txbuf_rdata, 32'd0);
        check("rst start_ready grant0", 32'(app_start_ready), 32'd0);
        udp_txbuf_grant = 1'b1;
        #1;
        check("rst start_ready grant1", 32'(app_start_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;

        // basic frame, table-driven readback
        set_pay_string("UDP Send Test");
        r0 = sent_cnt;
        send_frame(32'h0a01a8c0, 16'd1111, 16'd1234, 0, lat, rs, ds);
        check("basic rel", 32'(rs), 32'd1);
        check("basic latency", 32'(lat), 32'd4);
        check("basic sent_pulses", 32'(sent_cnt - r0), 32'd1);
        for (int i = 0; i < 7; i++) begin
            read_word(basic_tbl[i].addr, d);
            check($sformatf("basic word%0d", basic_tbl[i].addr), d, basic_tbl[i].exp);
        end

        // single byte
        pay.delete();
        pay.push_back(8'hab);
        frame_case("single", 32'h01020304, 16'h1000, 16'h2000, 0);
        for (int i = 0; i < 2; i++) begin
            read_word(single_tbl[i].addr, d);
            check($sformatf("single word%0d", single_tbl[i].addr), d, single_tbl[i].exp);
        end

        // gaps: same 8 bytes with and without idles
        pay.delete();
        for (int i = 0; i < 8; i++) pay.push_back(8'(8'h30 + i));
        frame_case("nogap8", 32'hc0a80002, 16'd5000, 16'd6000, 0);
        frame_case("gap8", 32'hc0a80002, 16'd5000, 16'd6000, 1);

        // grant drop after 5 bytes
        pay.delete();
        for (int i = 0; i < 10; i++) pay.push_back(8'($urandom));
        r0  = rel_cnt;
        dr0 = drop_cnt;
        @(negedge clk);
        wait_start_ready(ok);
        if (ok) begin
            do_start(32'h11111111, 16'h2222, 16'h3333);
            for (int k = 0; k < 5; k++) begin
                app_tvalid = 1'b1;
                app_tdata  = pay[k];
                @(negedge clk);
            end
            app_tdata       = pay[5];
            udp_txbuf_grant = 1'b0;
            #1;
            check("gdrop tready", 32'(app_tready), 32'd0);
            @(negedge clk);
            check("gdrop dropped", 32'(frame_dropped), 32'd1);
            check("gdrop busy", 32'(busy), 32'd0);
            @(negedge clk);
            check("gdrop dropped_pulse", 32'(frame_dropped), 32'd0);
            check("gdrop tready_after", 32'(app_tready), 32'd0);
            app_tvalid = 1'b0;
            repeat (3) @(negedge clk);
            check("gdrop no_rel", 32'(rel_cnt - r0), 32'd0);
            check("gdrop drop_pulses", 32'(drop_cnt - dr0), 32'd1);
            udp_txbuf_grant = 1'b1;
        end
        pay.delete();
        for (int i = 0; i < 11; i++) pay.push_back(8'($urandom));
        frame_case("after_gdrop", 32'h0a000001, 16'd7, 16'd9, 0);

        // reset mid payload
        pay.delete();
        for (int i = 0; i < 6; i++) pay.push_back(8'($urandom));
        read_word(0, d);
        dr0 = drop_cnt;
        r0  = rel_cnt;
        @(negedge clk);
        wait_start_ready(ok);
        if (ok) begin
            do_start(32'h55555555, 16'h6666, 16'h7777);
            for (int k = 0; k < 3; k++) begin
                app_tvalid = 1'b1;
                app_tdata  = pay[k];
                @(negedge clk);
            end
            rst = 1'b1;
            @(negedge clk);
            rst        = 1'b0;
            app_tvalid = 1'b0;
            check("mrst busy", 32'(busy), 32'd0);
            check("mrst tready", 32'(app_tready), 32'd0);
            check("mrst rel", 32'(udp_txbuf_rel), 32'd0);
            check("mrst sent", 32'(frame_sent), 32'd0);
            check("mrst dropped", 32'(frame_dropped), 32'd0);
            check("mrst rdata", udp_txbuf_rdata, 32'd0);
            check("mrst start_ready", 32'(app_start_ready), 32'd1);
            repeat (3) @(negedge clk);
            check("mrst no_drop", 32'(drop_cnt - dr0), 32'd0);
            check("mrst no_rel", 32'(rel_cnt - r0), 32'd0);
        end
        frame_case("after_mrst", 32'h0b0c0d0e, 16'd80, 16'd443, 0);

        // oversize
        pay.delete();
        for (int i = 0; i < 250; i++) pay.push_back(8'($urandom));
        send_frame(32'hdeadbeef, 16'h0102, 16'h0304, 0, lat, rs, ds);
`ifdef UDP_TXBUF_OVERSIZE_DROP_EN
        check("oversize dropped", 32'(ds), 32'd1);
        check("oversize no_rel", 32'(rs), 32'd0);
`else
        check("oversize rel", 32'(rs), 32'd1);
        check("oversize latency", 32'(lat), 32'd4);
        read_word(63, d);
        check("oversize word63", d, {pay[243], pay[242], pay[241], pay[240]});
        verify_frame("oversize", 32'hdeadbeef, 16'h0102, 16'h0304);
`endif

        // randomized frames against the reference image
        for (int f = 0; f < 8; f++) begin
            int n;
            n = $urandom_range(40, 1);
            pay.delete();
            for (int i = 0; i < n; i++) pay.push_back(8'($urandom));
            frame_case($sformatf("rand%0d", f), $urandom, 16'($urandom), 16'($urandom),
                       $urandom_range(2, 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
